// File: rtl/exc_commit_ctrl_pkg.sv
// Shared constants, FSM state enum and priority-encoder payload for the
// exception/interrupt commit sequencer.
package exc_commit_ctrl_pkg;

  localparam int unsigned PC_W_DEF = 32;
  localparam int unsigned EXC_W    = 5;
  localparam int unsigned ECODE_W  = 6;
  localparam int unsigned ESUB_W   = 9;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned STAT_W   = 32;

  localparam logic [ECODE_W-1:0] ECODE_INT = 6'h00;
  localparam logic [ECODE_W-1:0] ECODE_ADE = 6'h08;
  localparam logic [ECODE_W-1:0] ECODE_ALE = 6'h09;
  localparam logic [ECODE_W-1:0] ECODE_SYS = 6'h0B;
  localparam logic [ECODE_W-1:0] ECODE_BRK = 6'h0C;
  localparam logic [ECODE_W-1:0] ECODE_INE = 6'h0D;

  localparam logic [ESUB_W-1:0] ESUB_ADEF = 9'd0;

  localparam int unsigned EXC_ADEF = 0;
  localparam int unsigned EXC_INE  = 1;
  localparam int unsigned EXC_SYS  = 2;
  localparam int unsigned EXC_BRK  = 3;
  localparam int unsigned EXC_ALE  = 4;

  typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_REDIRECT, S_DRAIN} state_e;
  typedef enum logic [1:0] {K_NONE, K_INT, K_EXC, K_ERTN} kind_e;
  typedef enum logic [1:0] {BADV_NONE, BADV_PC, BADV_VADDR} badv_sel_e;

  typedef struct packed {
    kind_e               kind;
    logic [ECODE_W-1:0]  ecode;
    logic [ESUB_W-1:0]   esub;
    badv_sel_e           badv_sel;
  } prio_t;

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// WB / CSR / fetch-redirect signal bundle of the commit sequencer.
// master = sequencer side, slave = surrounding pipeline side.
interface exc_commit_ctrl_if
  import exc_commit_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
);
  logic               wb_valid;
  logic [PC_W-1:0]    wb_pc;
  logic [EXC_W-1:0]   wb_exc;
  logic [PC_W-1:0]    wb_vaddr;
  logic               wb_ertn;
  logic               has_int;
  logic [PC_W-1:0]    ex_entry;
  logic [PC_W-1:0]    era;
  logic               wb_block;
  logic               csr_wb_ex;
  logic [ECODE_W-1:0] csr_wb_ecode;
  logic [ESUB_W-1:0]  csr_wb_esubcode;
  logic [PC_W-1:0]    csr_wb_pc;
  logic               csr_ertn_flush;
  logic               csr_badv_we;
  logic [PC_W-1:0]    csr_badv;
  logic               flush_valid;
  logic [PC_W-1:0]    flush_target;
  logic               flush_ready;
  logic [STAT_W-1:0]  exc_count;
  logic [STAT_W-1:0]  int_count;

  modport master (
    input  wb_valid, wb_pc, wb_exc, wb_vaddr, wb_ertn, has_int, ex_entry, era, flush_ready,
    output wb_block, csr_wb_ex, csr_wb_ecode, csr_wb_esubcode, csr_wb_pc, csr_ertn_flush,
           csr_badv_we, csr_badv, flush_valid, flush_target, exc_count, int_count
  );

  modport slave (
    output wb_valid, wb_pc, wb_exc, wb_vaddr, wb_ertn, has_int, ex_entry, era, flush_ready,
    input  wb_block, csr_wb_ex, csr_wb_ecode, csr_wb_esubcode, csr_wb_pc, csr_ertn_flush,
           csr_badv_we, csr_badv, flush_valid, flush_target, exc_count, int_count
  );
endinterface

// File: rtl/exc_commit_ctrl_prio_enc.sv
// Combinational priority encoder: INT > ADEF > INE > SYS > BRK > ALE > ERTN.
module exc_prio_enc
  import exc_commit_ctrl_pkg::*;
(
  input  logic [EXC_W-1:0] i_exc,
  input  logic             i_has_int,
  input  logic             i_ertn,
  output prio_t            o_prio_c
);

  always_comb begin
    o_prio_c = '{kind: K_NONE, ecode: ECODE_INT, esub: '0, badv_sel: BADV_NONE};
    if (i_has_int) begin
      o_prio_c.kind = K_INT;
    end else if (i_exc[EXC_ADEF]) begin
      o_prio_c.kind     = K_EXC;
      o_prio_c.ecode    = ECODE_ADE;
      o_prio_c.esub     = ESUB_ADEF;
      o_prio_c.badv_sel = BADV_PC;
    end else if (i_exc[EXC_INE]) begin
      o_prio_c.kind  = K_EXC;
      o_prio_c.ecode = ECODE_INE;
    end else if (i_exc[EXC_SYS]) begin
      o_prio_c.kind  = K_EXC;
      o_prio_c.ecode = ECODE_SYS;
    end else if (i_exc[EXC_BRK]) begin
      o_prio_c.kind  = K_EXC;
      o_prio_c.ecode = ECODE_BRK;
    end else if (i_exc[EXC_ALE]) begin
      o_prio_c.kind     = K_EXC;
      o_prio_c.ecode    = ECODE_ALE;
      o_prio_c.badv_sel = BADV_VADDR;
    end else if (i_ertn) begin
      o_prio_c.kind = K_ERTN;
    end
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Exception/interrupt commit sequencer: IDLE -> COMMIT -> REDIRECT -> DRAIN.
// Optional macro EXC_CTRL_STATS_EN enables the exc/int commit counters.
module exc_commit_ctrl
  import exc_commit_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned PC_W         = PC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  exc_commit_ctrl_if.master bus
);

  localparam bit HAS_DRAIN = (DRAIN_CYCLES != 0);

  state_e             r_state;
  state_e             w_next_state;
  prio_t              w_prio;
  kind_e              r_kind;
  logic [ECODE_W-1:0] r_ecode;
  logic [ESUB_W-1:0]  r_esub;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_badv;
  logic               r_badv_we;
  logic [PC_W-1:0]    r_flush_tgt;
  logic [CNT_W-1:0]   r_drain_cnt;
  logic [PC_W-1:0]    w_commit_tgt;
  logic               w_event;
  logic               w_drain_load;
  logic               w_in_commit;
  logic               w_in_redirect;
  logic               w_is_exc;
  logic               w_ex_pulse;
  logic               w_badv_pulse;

  exc_prio_enc u_prio (
    .i_exc     (bus.wb_exc),
    .i_has_int (bus.has_int),
    .i_ertn    (bus.wb_ertn),
    .o_prio_c  (w_prio)
  );

  assign w_event       = bus.wb_valid && (w_prio.kind != K_NONE);
  assign w_in_commit   = (r_state == S_COMMIT);
  assign w_in_redirect = (r_state == S_REDIRECT);
  assign w_is_exc      = (r_kind == K_EXC) || (r_kind == K_INT);
  assign w_commit_tgt  = (r_kind == K_ERTN) ? bus.era : bus.ex_entry;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_drain_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_event) w_next_state = S_COMMIT;
      end
      S_COMMIT, S_REDIRECT: begin
        if (bus.flush_ready) begin
          if (HAS_DRAIN) begin
            w_next_state = S_DRAIN;
            w_drain_load = 1'b1;
          end else begin
            w_next_state = S_IDLE;
          end
        end else begin
          w_next_state = S_REDIRECT;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt <= CNT_W'(1)) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Event capture, redirect-target hold and drain counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kind      <= K_NONE;
      r_ecode     <= '0;
      r_esub      <= '0;
      r_pc        <= '0;
      r_badv      <= '0;
      r_badv_we   <= 1'b0;
      r_flush_tgt <= '0;
      r_drain_cnt <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_event) begin
        r_kind    <= w_prio.kind;
        r_ecode   <= w_prio.ecode;
        r_esub    <= w_prio.esub;
        r_pc      <= bus.wb_pc;
        r_badv_we <= (w_prio.badv_sel != BADV_NONE);
        r_badv    <= (w_prio.badv_sel == BADV_VADDR) ? bus.wb_vaddr :
                     (w_prio.badv_sel == BADV_PC)    ? bus.wb_pc    : '0;
      end
      if (w_in_commit) r_flush_tgt <= w_commit_tgt;
      if (w_drain_load) begin
        r_drain_cnt <= CNT_W'(DRAIN_CYCLES);
      end else if ((r_state == S_DRAIN) && (r_drain_cnt != '0)) begin
        r_drain_cnt <= r_drain_cnt - CNT_W'(1);
      end
    end
  end

  assign w_ex_pulse   = w_in_commit && w_is_exc;
  assign w_badv_pulse = w_in_commit && r_badv_we;

  // Outputs decode purely from flops, except the target sampled during COMMIT
  assign bus.wb_block        = (r_state != S_IDLE);
  assign bus.csr_wb_ex       = w_ex_pulse;
  assign bus.csr_wb_ecode    = w_ex_pulse ? r_ecode : '0;
  assign bus.csr_wb_esubcode = w_ex_pulse ? r_esub  : '0;
  assign bus.csr_wb_pc       = w_ex_pulse ? r_pc    : '0;
  assign bus.csr_ertn_flush  = w_in_commit && (r_kind == K_ERTN);
  assign bus.csr_badv_we     = w_badv_pulse;
  assign bus.csr_badv        = w_badv_pulse ? r_badv : '0;
  assign bus.flush_valid     = w_in_commit || w_in_redirect;
  assign bus.flush_target    = w_in_commit   ? w_commit_tgt :
                               w_in_redirect ? r_flush_tgt  : '0;

`ifdef EXC_CTRL_STATS_EN
  logic [STAT_W-1:0] r_exc_count;
  logic [STAT_W-1:0] r_int_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_exc_count <= '0;
      r_int_count <= '0;
    end else if (w_ex_pulse) begin
      r_exc_count <= r_exc_count + STAT_W'(1);
      if (r_kind == K_INT) r_int_count <= r_int_count + STAT_W'(1);
    end
  end

  assign bus.exc_count = r_exc_count;
  assign bus.int_count = r_int_count;
`else
  assign bus.exc_count = '0;
  assign bus.int_count = '0;
`endif

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: directed cases plus random events
// compared against a priority-table reference model.
module tb_exc_commit_ctrl;

  localparam int unsigned DRAIN = 2;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   m_exc;
  int   m_int;

  exc_commit_ctrl_if #(.PC_W(32)) bus ();

  exc_commit_ctrl #(.DRAIN_CYCLES(DRAIN), .PC_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Priority: INT, then lowest-numbered exception flag, then ERTN.
  // kind: 0 none, 1 int, 2 exception, 3 ertn
  function automatic void ref_decode(input logic [4:0] exc, input logic hi, input logic er,
                                     input logic [31:0] pc, input logic [31:0] va,
                                     output int kind, output logic [5:0] ec,
                                     output logic bwe, output logic [31:0] bv);
    int ectab [5];
    ectab = '{'h08, 'h0D, 'h0B, 'h0C, 'h09};
    kind = 0; ec = '0; bwe = 1'b0; bv = '0;
    if (hi) begin
      kind = 1;
    end else begin
      for (int b = 4; b >= 0; b--) begin
        if (exc[b]) begin
          kind = 2;
          ec   = 6'(ectab[b]);
          bwe  = (b == 0) || (b == 4);
          bv   = (b == 0) ? pc : ((b == 4) ? va : 32'h0);
        end
      end
      if (kind == 0 && er) kind = 3;
    end
  endfunction

  task automatic garbage();
    bus.wb_valid = 1'($urandom);
    bus.wb_exc   = 5'($urandom);
    bus.wb_ertn  = 1'($urandom);
    bus.has_int  = 1'($urandom);
    bus.wb_pc    = $urandom;
    bus.wb_vaddr = $urandom;
  endtask

  task automatic chk_counts(input string tag);
`ifdef EXC_CTRL_STATS_EN
    chk({tag, "_exc_count"}, 64'(bus.exc_count), 64'(m_exc));
    chk({tag, "_int_count"}, 64'(bus.int_count), 64'(m_int));
`else
    chk({tag, "_exc_count"}, 64'(bus.exc_count), 64'h0);
    chk({tag, "_int_count"}, 64'(bus.int_count), 64'h0);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_block"},  64'(bus.wb_block), 64'h0);
    chk({tag, "_wb_ex"},  64'(bus.csr_wb_ex), 64'h0);
    chk({tag, "_ecode"},  64'(bus.csr_wb_ecode), 64'h0);
    chk({tag, "_esub"},   64'(bus.csr_wb_esubcode), 64'h0);
    chk({tag, "_pc"},     64'(bus.csr_wb_pc), 64'h0);
    chk({tag, "_ertn"},   64'(bus.csr_ertn_flush), 64'h0);
    chk({tag, "_bwe"},    64'(bus.csr_badv_we), 64'h0);
    chk({tag, "_badv"},   64'(bus.csr_badv), 64'h0);
    chk({tag, "_fvalid"}, 64'(bus.flush_valid), 64'h0);
    chk({tag, "_ftgt"},   64'(bus.flush_target), 64'h0);
    chk_counts(tag);
  endtask

  // One full event: IDLE accept, COMMIT, `stall` REDIRECT cycles, DRAIN, back to IDLE
  task automatic do_event(input string tag, input logic [4:0] exc, input logic hi, input logic er,
                          input logic [31:0] pc, input logic [31:0] va,
                          input logic [31:0] entry, input logic [31:0] era_v, input int stall);
    int          kind;
    logic [5:0]  ec;
    logic        bwe;
    logic [31:0] bv;
    logic [31:0] tgt;
    logic        isx;
    ref_decode(exc, hi, er, pc, va, kind, ec, bwe, bv);
    isx = (kind == 1) || (kind == 2);
    tgt = (kind == 3) ? era_v : entry;

    @(posedge clk); #1;
    bus.wb_valid = 1'b1; bus.wb_exc = exc; bus.has_int = hi; bus.wb_ertn = er;
    bus.wb_pc = pc; bus.wb_vaddr = va; bus.ex_entry = entry; bus.era = era_v;
    bus.flush_ready = 1'($urandom);
    @(negedge clk);
    chk({tag, "_idle_block"}, 64'(bus.wb_block), 64'h0);
    chk({tag, "_idle_pulse"}, 64'(bus.csr_wb_ex | bus.csr_ertn_flush), 64'h0);

    @(posedge clk); #1;
    garbage();
    bus.flush_ready = (stall == 0);
    @(negedge clk);
    chk({tag, "_c_wb_ex"}, 64'(bus.csr_wb_ex), 64'(isx));
    chk({tag, "_c_ertn"},  64'(bus.csr_ertn_flush), 64'(kind == 3));
    chk({tag, "_c_bwe"},   64'(bus.csr_badv_we), 64'(bwe));
    chk({tag, "_c_fvalid"}, 64'(bus.flush_valid), 64'h1);
    chk({tag, "_c_ftgt"},  64'(bus.flush_target), 64'(tgt));
    chk({tag, "_c_block"}, 64'(bus.wb_block), 64'h1);
    if (isx) begin
      chk({tag, "_c_ecode"}, 64'(bus.csr_wb_ecode), 64'(ec));
      chk({tag, "_c_esub"},  64'(bus.csr_wb_esubcode), 64'h0);
      chk({tag, "_c_pc"},    64'(bus.csr_wb_pc), 64'(pc));
    end
    if (bwe) chk({tag, "_c_badv"}, 64'(bus.csr_badv), 64'(bv));

    for (int j = 1; j <= stall; j++) begin
      @(posedge clk); #1;
      garbage();
      bus.ex_entry = $urandom; bus.era = $urandom;
      bus.flush_ready = (j == stall);
      @(negedge clk);
      chk({tag, "_r_fvalid"}, 64'(bus.flush_valid), 64'h1);
      chk({tag, "_r_ftgt"},   64'(bus.flush_target), 64'(tgt));
      chk({tag, "_r_pulse"},  64'(bus.csr_wb_ex | bus.csr_ertn_flush | bus.csr_badv_we), 64'h0);
      chk({tag, "_r_block"},  64'(bus.wb_block), 64'h1);
    end

    for (int d = 0; d < int'(DRAIN); d++) begin
      @(posedge clk); #1;
      garbage();
      bus.flush_ready = 1'($urandom);
      @(negedge clk);
      chk({tag, "_d_block"},  64'(bus.wb_block), 64'h1);
      chk({tag, "_d_fvalid"}, 64'(bus.flush_valid), 64'h0);
      chk({tag, "_d_pulse"},  64'(bus.csr_wb_ex | bus.csr_ertn_flush | bus.csr_badv_we), 64'h0);
    end

    @(posedge clk); #1;
    bus.wb_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_e_block"},  64'(bus.wb_block), 64'h0);
    chk({tag, "_e_fvalid"}, 64'(bus.flush_valid), 64'h0);
    if (isx) m_exc++;
    if (kind == 1) m_int++;
    chk_counts(tag);
  endtask

  initial begin
    logic [4:0] r_exc;
    logic       r_hi;
    logic       r_er;
    total = 0; bad = 0; m_exc = 0; m_int = 0;
    reset = 1'b1;
    bus.wb_valid = 1'b0; bus.wb_exc = '0; bus.wb_ertn = 1'b0; bus.has_int = 1'b0;
    bus.wb_pc = '0; bus.wb_vaddr = '0; bus.ex_entry = '0; bus.era = '0; bus.flush_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    // Plain instructions and invalid flags must not start a sequence
    @(posedge clk); #1;
    bus.wb_valid = 1'b1; bus.wb_exc = '0;
    @(negedge clk); chk("plain_a_block", 64'(bus.wb_block), 64'h0);
    @(posedge clk); #1;
    bus.wb_valid = 1'b0; bus.wb_exc = 5'h1f; bus.has_int = 1'b1; bus.wb_ertn = 1'b1;
    @(negedge clk); chk("plain_b_block", 64'(bus.wb_block), 64'h0);
    @(posedge clk); #1;
    bus.wb_exc = '0; bus.has_int = 1'b0; bus.wb_ertn = 1'b0;
    @(negedge clk); chk("plain_c_block", 64'(bus.wb_block), 64'h0);

    do_event("sys",  5'b00100, 1'b0, 1'b0, 32'h1c000100, 32'h0, 32'h1c008000, 32'h0, 0);
    do_event("int",  5'b10001, 1'b1, 1'b0, 32'h1c000104, 32'h5, 32'h1c008000, 32'h0, 1);
    do_event("ale",  5'b10000, 1'b0, 1'b0, 32'h1c000108, 32'h3, 32'h1c008000, 32'h0, 0);
    do_event("ertn", 5'b00000, 1'b0, 1'b1, 32'h1c00010c, 32'h0, 32'h1c008000, 32'h1c000200, 4);
    do_event("ine_ertn", 5'b00010, 1'b0, 1'b1, 32'h1c000110, 32'h0, 32'h1c008000, 32'h1c000200, 0);
    do_event("adef", 5'b11111, 1'b0, 1'b1, 32'h1c000115, 32'h7, 32'h1c008040, 32'h1c000300, 2);

    // Reset while holding a redirect
    @(posedge clk); #1;
    bus.wb_valid = 1'b1; bus.wb_exc = 5'b00100; bus.wb_pc = 32'h1c000400;
    bus.ex_entry = 32'h1c008000; bus.flush_ready = 1'b0;
    @(posedge clk); #1;
    garbage(); bus.flush_ready = 1'b0;
    @(posedge clk); #1;
    garbage(); bus.flush_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_fvalid", 64'(bus.flush_valid), 64'h1);
    chk("pre_rst_block",  64'(bus.wb_block), 64'h1);
    @(posedge clk); #1;
    reset = 1'b1; bus.wb_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; bus.wb_valid = 1'b0;
    m_exc = 0; m_int = 0;
    @(negedge clk);
    chk_all_zero("mid_rst");
    do_event("post_rst_sys", 5'b00100, 1'b0, 1'b0, 32'h1c000500, 32'h0, 32'h1c008000, 32'h0, 1);

    for (int n = 0; n < 40; n++) begin
      r_exc = ($urandom_range(0, 2) == 0) ? 5'h0 : 5'($urandom);
      r_hi  = ($urandom_range(0, 3) == 0);
      r_er  = 1'($urandom);
      if (!r_hi && r_exc == 5'h0) r_er = 1'b1;
      do_event("rnd", r_exc, r_hi, r_er, $urandom, $urandom, $urandom, $urandom,
               int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
Exception/interrupt commit sequencer between the writeback stage and the control/status register file. Prioritises the WB instruction's exception flags, pending interrupt and ERTN, then issues a single-cycle commit pulse (wb_ex + ecode/esubcode, or ertn_flush) to the CSR block. It then holds a pipeline redirect request until accepted and stalls WB during a fixed drain window. All sequencing runs on a four-state FSM.

Parameters:
DRAIN_CYCLES, 2, cycles WB stays blocked after redirect acceptance; legal 0..15
PC_W, 32, PC / address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wb_valid  in  1  valid instruction in WB
wb_pc  in  PC_W  PC of WB instruction
wb_exc  in  5  flags: [0]ADEF [1]INE [2]SYS [3]BRK [4]ALE
wb_vaddr  in  PC_W  faulting address for ALE
wb_ertn  in  1  WB instruction is ERTN
has_int  in  1  pending enabled interrupt from CSR
ex_entry  in  PC_W  exception entry from CSR
era  in  PC_W  current ERA from CSR
wb_block  out  1  WB must not retire (state != IDLE)
csr_wb_ex  out  1  exception commit pulse to CSR
csr_wb_ecode  out  6  ecode to CSR
csr_wb_esubcode  out  9  esubcode to CSR
csr_wb_pc  out  PC_W  PC written to ERA
csr_ertn_flush  out  1  ERTN commit pulse to CSR
csr_badv_we  out  1  BADV write strobe
csr_badv  out  PC_W  BADV value
flush_valid  out  1  pipeline redirect request
flush_target  out  PC_W  redirect PC
flush_ready  in  1  redirect accepted by fetch
exc_count  out  32  exceptions taken (see optional feature)
int_count  out  32  interrupts taken (see optional feature)

Behaviour:
- Reset: state IDLE; every output 0; latched fields 0; drain counter 0. Reset mid-sequence aborts cleanly, with no further CSR pulse and no flush_valid in the following cycle.
- States: IDLE, COMMIT, REDIRECT, DRAIN.
- IDLE:
  - Event = wb_valid & (has_int | |wb_exc | wb_ertn).
  - On an event: latch kind, ecode, esubcode, wb_pc and badv; go to COMMIT next cycle.
  - Non-event instructions retire freely; wb_block = 0.
- Priority, highest first:
  - INT: ecode 0x00, esub 0.
  - ADEF: 0x08, esub 0, badv = wb_pc.
  - INE: 0x0D.
  - SYS: 0x0B.
  - BRK: 0x0C.
  - ALE: 0x09, badv = wb_vaddr.
  - ERTN: only when there is no interrupt and no flag.
  - Any exception overrides a simultaneous ERTN.
- COMMIT (exactly 1 cycle):
  - Exception: csr_wb_ex = 1 with the latched ecode/esubcode/pc.
  - ERTN: csr_ertn_flush = 1.
  - csr_badv_we = 1 only for ADEF/ALE.
  - flush_valid = 1; flush_target = ex_entry for exceptions, era for ERTN, sampled this cycle and held until accepted.
  - If flush_ready is high this cycle: go to DRAIN (or straight to IDLE when DRAIN_CYCLES = 0). Otherwise go to REDIRECT.
- REDIRECT: flush_valid = 1 with a stable target until flush_ready; then go to DRAIN (or IDLE when DRAIN_CYCLES = 0). No CSR pulses in this state.
- DRAIN: counter loads DRAIN_CYCLES on entry and decrements each cycle; go to IDLE in the cycle after it reaches 1.
- wb_block = 1 in COMMIT, REDIRECT and DRAIN. WB inputs are ignored outside IDLE.
- Latency:
  - Event accepted in cycle T gives the CSR pulse in T+1.
  - Earliest IDLE is T+2 when DRAIN_CYCLES = 0 and flush_ready is high at T+1.
  - Earliest IDLE is T+2+DRAIN_CYCLES otherwise.
- CSR pulses never last longer than one cycle and never repeat per event.

Optional Feature:
EXC_CTRL_STATS_EN
- Defined:
  - exc_count increments in each COMMIT carrying any exception, including INT.
  - int_count increments only for INT.
  - Both wrap at 2^32 and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Shared package: ecode constants (INT, ADE, ALE, SYS, BRK, INE), esubcode constant ADEF = 0, FSM state enum, wb_exc bit indices.
- One natural sub-module: exc_prio_enc (combinational priority encoder taking flags + has_int + ertn, producing kind/ecode/esubcode/badv-select).

Test Plan:
- wb_valid = 1, wb_exc = 5'b00100, pc 0x1c000100, ex_entry 0x1c008000, flush_ready = 1 -> T+1: csr_wb_ex = 1, ecode 0x0B, csr_wb_pc 0x1c000100, flush_target 0x1c008000; wb_block high for 1+2 cycles, then IDLE.
- has_int = 1 together with wb_exc = 5'b10001 -> ecode 0x00, csr_badv_we = 0; int_count +1 when EXC_CTRL_STATS_EN is defined.
- wb_exc = 5'b10000, wb_vaddr 0x00000003 -> ecode 0x09, csr_badv_we = 1, csr_badv 0x00000003.
- wb_ertn = 1, era 0x1c000200, flush_ready held low 4 cycles -> one-cycle csr_ertn_flush; flush_valid held 5 cycles at 0x1c000200; no second pulse.
- wb_ertn = 1 with wb_exc = 5'b00010 -> csr_wb_ex with ecode 0x0D; csr_ertn_flush stays 0.
- reset asserted in REDIRECT -> next cycle all outputs 0, state IDLE; a subsequent SYS event is handled normally.
